// File: rtl/wb_pkg.sv
// Shared state encoding, bus widths and address-window decode for the Wishbone-to-native bridge.
package wb_pkg;

   localparam int WB_DW   = 32;
   localparam int WB_SELW = 4;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      REQ  = 2'b01,
      RESP = 2'b10
   } wb_state_e;

   function automatic logic wb_hit(
      input logic [WB_DW-1:0] adr,
      input logic [WB_DW-1:0] base,
      input logic [WB_DW-1:0] mask
   );
      return (adr & ~mask) == base;
   endfunction

endpackage

// File: rtl/wb_native_slave_bridge.sv
// Wishbone classic slave that re-issues accepted cycles as a native mem_valid/mem_ready request.
// Optional WBS_ERR_EN adds wbs_err_o, error on window miss and a native wait timeout.
//
// state | meaning
// IDLE  | waiting for cyc & stb; decodes the window
// REQ   | native request outstanding, mem_* held until mem_ready (or timeout)
// RESP  | one-cycle ack/err back to the Wishbone master
module wb_native_slave_bridge
   import wb_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
   parameter logic [31:0] ADDR_MASK      = 32'h0000_FFFF,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic [WB_DW-1:0]   wbs_adr_i,
   input  logic [WB_DW-1:0]   wbs_dat_i,
   output logic [WB_DW-1:0]   wbs_dat_o,
   input  logic               wbs_we_i,
   input  logic [WB_SELW-1:0] wbs_sel_i,
   input  logic               wbs_stb_i,
   input  logic               wbs_cyc_i,
   output logic               wbs_ack_o,
`ifdef WBS_ERR_EN
   output logic               wbs_err_o,
`endif
   output logic               mem_valid,
   output logic [WB_DW-1:0]   mem_addr,
   output logic [WB_DW-1:0]   mem_wdata,
   output logic [WB_SELW-1:0] mem_wstrb,
   input  logic               mem_ready,
   input  logic [WB_DW-1:0]   mem_rdata
);

   if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be within 1..65535");
   end

   wb_state_e            state_q, state_d;
   logic                 mem_valid_d;
   logic [WB_DW-1:0]     mem_addr_d, mem_wdata_d, dat_d;
   logic [WB_SELW-1:0]   mem_wstrb_d;
   logic                 we_q, we_d;
   logic                 aborted_q, aborted_d;
   logic                 ack_d;
   logic                 hit;

   assign hit = wb_hit(wbs_adr_i, BASE_ADDR, ADDR_MASK);

`ifdef WBS_ERR_EN
   logic                 err_d;
   logic [15:0]          cnt_q, cnt_d;
   logic                 expired;

   // cnt_q counts waited REQ cycles; expiry leaves exactly TIMEOUT_CYCLES cycles of mem_valid.
   assign expired = (cnt_q == 16'(TIMEOUT_CYCLES - 1));
`endif

   always_comb begin
      state_d     = state_q;
      mem_valid_d = mem_valid;
      mem_addr_d  = mem_addr;
      mem_wdata_d = mem_wdata;
      mem_wstrb_d = mem_wstrb;
      dat_d       = wbs_dat_o;
      we_d        = we_q;
      aborted_d   = aborted_q;
      ack_d       = 1'b0;
`ifdef WBS_ERR_EN
      err_d       = 1'b0;
      cnt_d       = cnt_q;
`endif
      case (state_q)
         IDLE: begin
            if (wbs_cyc_i && wbs_stb_i) begin
               if (hit) begin
                  mem_valid_d = 1'b1;
                  mem_addr_d  = wbs_adr_i & ADDR_MASK;
                  mem_wdata_d = wbs_dat_i;
                  mem_wstrb_d = wbs_we_i ? wbs_sel_i : '0;
                  we_d        = wbs_we_i;
                  aborted_d   = 1'b0;
`ifdef WBS_ERR_EN
                  cnt_d       = '0;
`endif
                  state_d     = REQ;
               end else begin
                  dat_d = '0;
`ifdef WBS_ERR_EN
                  err_d = 1'b1;
`else
                  ack_d = 1'b1;
`endif
                  state_d = RESP;
               end
            end
         end
         REQ: begin
            // A dropped cycle cannot cancel the native side; remember it and swallow the response.
            if (!wbs_cyc_i) aborted_d = 1'b1;
            if (mem_ready) begin
               mem_valid_d = 1'b0;
               if (aborted_q || !wbs_cyc_i) begin
                  state_d = IDLE;
               end else begin
                  ack_d = 1'b1;
                  if (!we_q) dat_d = mem_rdata;
                  state_d = RESP;
               end
            end
`ifdef WBS_ERR_EN
            else if (expired) begin
               mem_valid_d = 1'b0;
               if (aborted_q || !wbs_cyc_i) begin
                  state_d = IDLE;
               end else begin
                  err_d   = 1'b1;
                  state_d = RESP;
               end
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
`endif
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q   <= IDLE;
         mem_valid <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_wstrb <= '0;
         wbs_dat_o <= '0;
         wbs_ack_o <= 1'b0;
         we_q      <= 1'b0;
         aborted_q <= 1'b0;
`ifdef WBS_ERR_EN
         wbs_err_o <= 1'b0;
         cnt_q     <= '0;
`endif
      end else begin
         state_q   <= state_d;
         mem_valid <= mem_valid_d;
         mem_addr  <= mem_addr_d;
         mem_wdata <= mem_wdata_d;
         mem_wstrb <= mem_wstrb_d;
         wbs_dat_o <= dat_d;
         wbs_ack_o <= ack_d;
         we_q      <= we_d;
         aborted_q <= aborted_d;
`ifdef WBS_ERR_EN
         wbs_err_o <= err_d;
         cnt_q     <= cnt_d;
`endif
      end
   end

endmodule
